// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display request and multiplexed scan outputs
//   seg_value/dec_mode/blink: value to show, decimal select, blink request
//   seg_an/seg_ca: active-low anodes and cathodes {dp,g..a}; conv_busy: BCD conversion running
interface seg7_scan_driver_if;
  logic [23:0] seg_value;
  logic        dec_mode;
  logic        blink;
  logic [7:0]  seg_an;
  logic [7:0]  seg_ca;
  logic        conv_busy;
  modport master(output seg_value, dec_mode, blink, input seg_an, seg_ca, conv_busy);
  modport slave(input seg_value, dec_mode, blink, output seg_an, seg_ca, conv_busy);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed 7-segment driver with hex/decimal display and blink
//   clk, rst_n: clock and synchronous active-low reset
//   bus (slave): seg_value/dec_mode/blink in; seg_an/seg_ca/conv_busy out (all registered)
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input logic              clk,
  input logic              rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  // cathode patterns for 0..F, digit 0 in the low byte
  localparam logic [127:0] SEG_LUT = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  state_t        state_q, state_d;
  logic [23:0]   in_q, in_d, last_val_q, last_val_d, snap_val_q, snap_val_d, bin_q, bin_d;
  logic          mode_q, mode_d, last_mode_q, last_mode_d, snap_mode_q, snap_mode_d;
  logic [31:0]   bcd_q, bcd_d, bcd_adj, dig_q, dig_d;
  logic [4:0]    it_q, it_d;
  logic [SW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, phase_d;
  logic [7:0]    an_q, an_d, ca_q, ca_d;
  logic          busy_q, busy_d;
  logic [3:0]    cur;
  logic          blank;
  assign bus.seg_an    = an_q;
  assign bus.seg_ca    = ca_q;
  assign bus.conv_busy = busy_q;
  always_comb begin
    in_d        = bus.seg_value;
    mode_d      = bus.dec_mode;
    state_d     = state_q;
    snap_val_d  = snap_val_q;
    snap_mode_d = snap_mode_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    it_d        = it_q;
    dig_d       = dig_q;
    last_val_d  = last_val_q;
    last_mode_d = last_mode_q;
    bcd_adj     = bcd_q;
    for (int i = 0; i < 8; i++)
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    case (state_q)
      IDLE: if ({in_q, mode_q} != {last_val_q, last_mode_q}) begin
        snap_val_d  = in_q;
        snap_mode_d = mode_q;
        bin_d       = in_q;
        bcd_d       = '0;
        it_d        = '0;
        state_d     = mode_q ? CONV : LOAD;
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        it_d           = it_q + 5'd1;
        state_d        = it_q == 5'd23 ? LOAD : CONV;
      end
      LOAD: begin
        // hex leaves digits 6-7 at zero, so leading-zero blanking hides them
        dig_d       = snap_mode_q ? bcd_q : {8'h00, snap_val_q};
        last_val_d  = snap_val_q;
        last_mode_d = snap_mode_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    div_d   = div_q == SW'(SCAN_DIV - 1) ? '0 : div_q + SW'(1);
    idx_d   = div_q == SW'(SCAN_DIV - 1) ? idx_q + 3'd1 : idx_q;
    blk_d   = (!bus.blink || blk_q == BW'(BLINK_DIV - 1)) ? '0 : blk_q + BW'(1);
    phase_d = bus.blink && (blk_q == BW'(BLINK_DIV - 1) ? !phase_q : phase_q);
    // outputs are built from next-state values so a load shows on the same edge it lands
    cur     = dig_d[{idx_d, 2'b00} +: 4];
    blank   = idx_d != 3'd0 && (dig_d >> {idx_d, 2'b00}) == 32'd0;
    an_d    = (blank || phase_d) ? 8'hFF : ~(8'd1 << idx_d);
    ca_d    = blank ? 8'hFF : SEG_LUT[{cur, 3'b000} +: 8];
    busy_d  = state_d == CONV;
  end
  always_ff @(posedge clk) begin
    in_q   <= in_d;
    mode_q <= mode_d;
    if (!rst_n) begin
      state_q     <= IDLE;
      snap_val_q  <= '0;
      snap_mode_q <= 1'b0;
      bcd_q       <= '0;
      bin_q       <= '0;
      it_q        <= '0;
      dig_q       <= '0;
      last_val_q  <= '0;
      last_mode_q <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      blk_q       <= '0;
      phase_q     <= 1'b0;
      an_q        <= 8'hFF;
      ca_q        <= 8'hFF;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_val_q  <= snap_val_d;
      snap_mode_q <= snap_mode_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      it_q        <= it_d;
      dig_q       <= dig_d;
      last_val_q  <= last_val_d;
      last_mode_q <= last_mode_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      blk_q       <= blk_d;
      phase_q     <= phase_d;
      an_q        <= an_d;
      ca_q        <= ca_d;
      busy_q      <= busy_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  seg7_scan_driver_if bus();
  seg7_scan_driver #(.SCAN_DIV(2), .BLINK_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    int         slot;
    logic [7:0] an;
    logic [7:0] ca;
  } exp_t;
  exp_t  sq[$];
  int    bq[$];
  int    bl[$];
  exp_t  me;
  int    tests = 0, fails = 0, k = 0, blen = 0, pulses = 0, run = 0;
  logic  bl_arm = 1'b0, bl_started = 1'b0, bl_first = 1'b0, prev_off = 1'b0;
  string tag = "none";
  always @(posedge clk) k <= rst_n ? k + 1 : 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out", nm);
  endtask
  always @(negedge clk) begin
    if (!rst_n) blen = 0;
    else begin
      if (bus.conv_busy) blen++;
      else if (blen > 0) begin
        pulses++;
        if (bq.size() == 0) chk("unexpected_busy_pulse", blen, 0);
        else chk("busy_len", blen, bq.pop_front());
        blen = 0;
      end
      if (k % 2 == 1 && sq.size() > 0 && sq[0].slot == (k / 2) % 8) begin
        me = sq.pop_front();
        chk($sformatf("%s_an_slot%0d", tag, me.slot), bus.seg_an, me.an);
        chk($sformatf("%s_ca_slot%0d", tag, me.slot), bus.seg_ca, me.ca);
      end
      if (bl_arm) begin
        if (!bl_started) begin
          bl_started = 1'b1;
          bl_first   = 1'b1;
          prev_off   = bus.seg_an == 8'hFF;
          run        = 1;
        end else if ((bus.seg_an == 8'hFF) == prev_off) run++;
        else begin
          if (!bl_first && bl.size() > 0) chk(prev_off ? "blink_off_len" : "blink_on_len", run, bl.pop_front());
          bl_first = 1'b0;
          prev_off = !prev_off;
          run      = 1;
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_frame(input string nm, input logic [63:0] cas);
    exp_t e;
    int   s;
    s   = ((k / 2) + 1) % 8;
    tag = nm;
    for (int i = 0; i < 8; i++) begin
      e.slot = (s + i) % 8;
      e.ca   = cas[8*e.slot +: 8];
      e.an   = e.ca == 8'hFF ? 8'hFF : ~(8'd1 << e.slot);
      sq.push_back(e);
    end
  endtask
  task automatic wait_frame();
    int n;
    n = 0;
    while (sq.size() > 0 && n < 40) begin step(1); n++; end
    if (sq.size() > 0) begin timeout({tag, "_frame"}); sq.delete(); end
  endtask
  task automatic wait_busy(input string nm);
    int n;
    n = 0;
    while (bq.size() > 0 && n < 100) begin step(1); n++; end
    if (bq.size() > 0) begin timeout(nm); bq.delete(); end
  endtask
  initial begin
    int n;
    int p;
    logic [63:0] hx;
    bus.seg_value = 24'h123456;
    bus.dec_mode  = 1'b0;
    bus.blink     = 1'b0;
    step(3);
    chk("rst_an", bus.seg_an, 8'hFF);
    chk("rst_ca", bus.seg_ca, 8'hFF);
    chk("rst_busy", bus.conv_busy, 1'b0);
    bus.seg_value = 24'h0;
    step(1);
    rst_n = 1'b1;
    step(2);
    push_frame("reset", 64'hFFFF_FFFF_FFFF_FFC0);
    wait_frame();
    bq.push_back(24);
    bus.dec_mode  = 1'b1;
    bus.seg_value = 24'd1234567;
    wait_busy("busy_1234567");
    step(2);
    push_frame("dec1234567", 64'hFFF9_A4B0_9992_82F8);
    wait_frame();
    bq.push_back(24);
    bus.seg_value = 24'hFFFFFF;
    wait_busy("busy_max");
    step(2);
    push_frame("decmax", 64'hF982_F8F8_F8A4_F992);
    wait_frame();
    p  = pulses;
    hx = 64'hFFFF_FFFF_88C0_928E;
    bus.dec_mode  = 1'b0;
    bus.seg_value = 24'h00A05F;
    step(3);
    chk("hex_latency_ca", bus.seg_ca, hx[8*((k/2)%8) +: 8]);
    push_frame("hexA05F", hx);
    wait_frame();
    chk("hex_no_busy", pulses, p);
    bq.push_back(24);
    bq.push_back(24);
    bus.dec_mode  = 1'b1;
    bus.seg_value = 24'd100;
    n = 0;
    while (!bus.conv_busy && n < 10) begin step(1); n++; end
    if (!bus.conv_busy) timeout("busy_rise_100");
    step(10);
    bus.seg_value = 24'd200;
    n = 0;
    while (bus.conv_busy && n < 40) begin step(1); n++; end
    push_frame("dec100", 64'hFFFF_FFFF_FFF9_C0C0);
    wait_frame();
    wait_busy("busy_200");
    step(2);
    push_frame("dec200", 64'hFFFF_FFFF_FFA4_C0C0);
    wait_frame();
    p = pulses;
    bus.dec_mode = 1'b0;
    step(3);
    push_frame("hex200", 64'hFFFF_FFFF_FFFF_C680);
    wait_frame();
    chk("mode_hex_no_busy", pulses, p);
    bq.push_back(24);
    bus.dec_mode  = 1'b1;
    bus.seg_value = 24'hFFFFFF;
    wait_busy("busy_max2");
    step(2);
    bus.blink = 1'b1;
    step(1);
    repeat (6) bl.push_back(4);
    bl_arm = 1'b1;
    n = 0;
    while (bl.size() > 0 && n < 100) begin step(1); n++; end
    if (bl.size() > 0) begin timeout("blink_runs"); bl.delete(); end
    bl_arm = 1'b0;
    n = 0;
    while (bus.seg_an != 8'hFF && n < 10) begin step(1); n++; end
    chk("blink_off_seen", bus.seg_an, 8'hFF);
    bus.blink = 1'b0;
    n = 0;
    while (bus.seg_an == 8'hFF && n < 3) begin step(1); n++; end
    tests++;
    if (n > 2) begin fails++; $display("FAIL blink_resume: took %0d cycles, limit 2", n); end
    for (int i = 0; i < 10; i++) begin
      chk("blink_held_visible", bus.seg_an == 8'hFF, 1'b0);
      step(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream consumer of the IO stage's 24-bit seven-segment word and blink flag; drives the board's 8-digit multiplexed common-anode display. Converts the word to eight display digits, either hexadecimal or decimal, using a sequential double-dabble converter. Scans the digits with a programmable refresh divider, blanks leading zeros, and gates the whole display with a blink phase while blink is asserted.

## Interface
- `SCAN_DIV`, 100000: clocks per digit slot (1 kHz digit rate at 100 MHz).
- `BLINK_DIV`, 50000000: clocks per blink half-period.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `seg_value` in 24: value to display, from the IO stage seven-segment output.
- `blink` in 1: blink request, from the IO stage blink output.
- `dec_mode` in 1: 1 selects decimal (8 digits); 0 selects hex (6 digits).
- `seg_an` out 8: digit anodes, active-low; bit i is digit i; digit 0 is least significant.
- `seg_ca` out 8: cathodes, active-low, ordered {dp,g,f,e,d,c,b,a}; dp is always 1.
- `conv_busy` out 1: high while the FSM is in CONV.

## Operation
- Input stage:
  - `in_q` and `mode_q` register `seg_value` and `dec_mode` every cycle.
  - `last_val` and `last_mode` hold the pair that was last loaded into the display.
- FSM states: IDLE, CONV, LOAD.
  - IDLE: if `{in_q,mode_q}` differs from `{last_val,last_mode}`, snapshot `in_q` and `mode_q`.
    - Snapshot mode = 1: go to CONV. Clear the 32-bit BCD register and the 5-bit iteration count.
    - Snapshot mode = 0: go to LOAD directly.
  - CONV: each cycle, add 3 to every BCD nibble that is ≥5, then shift `{bcd,bin}` left by 1. Run exactly 24 iterations, then go to LOAD.
  - LOAD: write the 8 display digits and update `last_val`/`last_mode` from the snapshot. Return to IDLE.
    - Hex mode: digits 0–5 are the nibbles of the snapshot; digits 6–7 are forced blank.
    - Decimal mode: digits 0–7 are the BCD nibbles.
  - Input changes during CONV or LOAD are ignored until the FSM is back in IDLE. They are then detected by the compare, so the display always converges to the latest input.
- Leading-zero blanking:
  - Digit i is blank if it and every higher digit are 0, for i ≥ 1.
  - Digit 0 is never blank, so value 0 shows a single "0".
- Scan:
  - `div_cnt` counts 0..SCAN_DIV-1. At the wrap, `idx` (3 bits) increments and wraps 7→0.
  - Otherwise: `seg_an` = ~(1<<idx), and `seg_ca` = decode(digit[idx]).
  - Blanked digit: `seg_an` = 8'hFF and `seg_ca` = 8'hFF.
- Segment decode, bit7 = 1:
  - 0..7: C0, F9, A4, B0, 99, 92, 82, F8.
  - 8..F: 80, 90, 88, 83, C6, A1, 86, 8E.
- Blink:
  - While `blink` = 1: `blk_cnt` counts 0..BLINK_DIV-1, and `phase` toggles at each wrap. While `phase` = 1, `seg_an` = 8'hFF.
  - While `blink` = 0: `blk_cnt` and `phase` are held at 0.

## Timing
- Reset (`rst_n` low at an edge) sets:
  - outputs: `seg_an` = 8'hFF, `seg_ca` = 8'hFF, `conv_busy` = 0;
  - state: FSM = IDLE, all digits = 0 (display "0" after reset release), `last_val` = 0, `last_mode` = 0, `idx` = 0, `div_cnt` = 0, `blk_cnt` = 0, `phase` = 0.
  - Reset mid-CONV aborts the conversion with no partial display update.
- Outputs `seg_an`, `seg_ca` and `conv_busy` are registered. The digit update of a load appears on `seg_an`/`seg_ca` one edge after LOAD, within the current digit slot.
- Latency from a `seg_value` change at edge n (FSM idle):
  - Decimal: `in_q` at n, CONV entered at n+1, `conv_busy` high for exactly 24 cycles, LOAD at n+25, digits valid at n+26.
  - Hex: LOAD at n+1, digits valid at n+2.
- Changing only `dec_mode` triggers a reconversion of the same value.
- `blink` falling: `phase` clears on the next edge, and the display is visible from the following cycle.
- Worst-case update latency after a change during CONV: 2×26 cycles.

## Test plan
- Reset: hold `rst_n` = 0 for 3 edges with `seg_value` = 24'h123456 → `seg_an` = FF, `seg_ca` = FF, `conv_busy` = 0. After release, digit 0 shows C0 and digits 1–7 are blank (`seg_an` = FF in their slots).
- Decimal (`SCAN_DIV` = 2, `dec_mode` = 1, `seg_value` = 1234567):
  - `conv_busy` is high for exactly 24 cycles.
  - Slots 0..6 give `seg_ca` = F8, 82, 92, 99, B0, A4, F9.
  - Slot 7 gives `seg_an` = FF.
- Decimal maximum: `seg_value` = 24'hFFFFFF with `dec_mode` = 1 → digits 0..7 = 5,1,2,7,7,7,6,1 (16777215); all 8 anodes are active in turn.
- Hex with blanking: `dec_mode` = 0, `seg_value` = 24'h00A05F → digits F, 5, 0, A (8E, 92, C0, 88); slots 4–7 are blank; `conv_busy` never rises; digits are valid 2 cycles after the input change.
- Change during CONV: `dec_mode` = 1, `seg_value` = 100, then 200 at CONV cycle 10 → 100 is displayed, then a second 24-cycle CONV runs and 200 is displayed.
- Blink (`BLINK_DIV` = 4):
  - `blink` = 1 → `seg_an` alternates between 4 cycles of scanning and 4 cycles of FF.
  - Deasserting `blink` during an FF phase → scanning resumes within 2 cycles.
